pkt_fifo_drain_sorter: RTL and testbench
========================================

// Module: pkt_fifo_drain_sorter
// PURPOSE
//  Downstream consumer of the 32-bit sync FIFO in the packet validator/sorter path.
//  Pops one single-word packet at a time and checks its sync nibble and XOR checksum.
//  Valid packets go to a registered valid/ready output stream, tagged with a 2-bit class.
//  Invalid packets are dropped and counted; ok/drop counters and sticky error flags feed AXI-Lite status.
// PARAMETERS
//  SYNC_NIBBLE  4'hA  required value of word[31:28]
//  CNT_WIDTH    16    width of the saturating ok/drop counters
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  rst_n         in   1          asynchronous active-low reset
//  fifo_rd_data  in   32         FIFO read data; valid the cycle after a successful pop
//  fifo_empty    in   1          FIFO empty flag
//  fifo_rd_en    out  1          FIFO pop request
//  enable        in   1          1 = drain FIFO; 0 = finish current word, then stop popping
//  out_valid     out  1          output word valid
//  out_ready     in   1          downstream accepts word
//  out_data      out  32         accepted packet word, unmodified
//  out_class     out  2          word[27:26] of the packet
//  cnt_clr       in   1          synchronous clear of counters and sticky flags
//  ok_cnt        out  CNT_WIDTH  packets forwarded (counted on acceptance check)
//  drop_cnt      out  CNT_WIDTH  packets dropped
//  err_sync      out  1          sticky: a packet failed the sync check
//  err_csum      out  1          sticky: a packet failed the checksum check
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output and counter = 0; any held word is discarded.
//  Packet format: [31:28] sync, [27:26] class, [25:8] payload, [7:0] csum.
//  Checksum rule: csum = w[31:24]^w[23:16]^w[15:8]. Packet is good iff sync and csum both match.
//  FSM:
//  - IDLE: fifo_rd_en = enable & ~fifo_empty (combinational). If fifo_rd_en=1, go to CHECK; else stay.
//  - CHECK: fifo_rd_data holds the popped word; fifo_rd_en=0.
//    If good: register out_data and out_class, set out_valid=1, ok_cnt+1, go to OUT.
//    If bad: drop_cnt+1; err_sync|=sync mismatch; err_csum|=csum mismatch (both may set); go to IDLE.
//  - OUT: out_valid=1; out_data and out_class are held stable. fifo_rd_en=0.
//    When out_valid & out_ready: out_valid=0 next cycle, go to IDLE.
//  Latency: pop cycle -> out_valid rises 2 edges later. Max rate is one word per 3 cycles.
//  fifo_rd_en is never asserted when fifo_empty=1 and never asserted outside IDLE.
//  enable deasserted in CHECK or OUT: the current word completes normally; no new pop occurs.
//  Counters saturate at all-ones and do not wrap.
//  cnt_clr=1 zeroes ok_cnt, drop_cnt, err_sync and err_csum next edge. Clear wins over a same-cycle increment.
//  cnt_clr does not affect the FSM or the output stream.
//  out_ready is ignored while out_valid=0.
// TESTING
//  1 FIFO holds 0xA12345C7, out_ready=1 -> pop; 2 edges later out_valid=1, out_data=0xA12345C7,
//    out_class=0; ok_cnt=1.
//  2 FIFO holds 0xAC12348A, out_ready=0 for 5 cycles -> out_valid held, data stable, class=3,
//    no further pop while held; accepted on the cycle out_ready=1.
//  3 FIFO holds 0xAC12348B -> no out_valid; drop_cnt=1, err_csum=1, err_sync=0.
//    FIFO holds 0x5C12347A -> drop_cnt=2, err_sync=1.
//  4 FIFO empty, enable=1 for 10 cycles -> fifo_rd_en stays 0. 4 good words back-to-back, out_ready=1
//    -> pops spaced exactly 3 cycles; ok_cnt=4.
//  5 Preload ok_cnt=0xFFFF (CNT_WIDTH=16), send 1 good word -> ok_cnt stays 0xFFFF.
//    cnt_clr in the same cycle as an increment -> ok_cnt=0.
//  6 Assert rst_n=0 while in OUT holding 0xA12345C7 -> out_valid=0, out_data=0, counters=0 immediately.
//    After release with the FIFO empty, FSM idles.

Source files
------------

// File: rtl/pkt_fifo_drain_sorter.sv
// Drains single-word packets from a sync FIFO, validates sync nibble and XOR checksum,
// forwards good words on a registered valid/ready stream and counts/flags dropped ones.
module pkt_fifo_drain_sorter #(
  parameter logic [3:0] SYNC_NIBBLE = 4'hA,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          fifo_rd_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [1:0]           out_class,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] ok_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 err_sync,
  output logic                 err_csum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic       sync_bad;
  logic       csum_bad;
  logic [7:0] csum_calc;
  logic       load_out;
  logic       out_release;
  logic       ok_inc;
  logic       drop_inc;

  // Checks are only meaningful in CHECK, where the popped word is on fifo_rd_data.
  assign csum_calc = fifo_rd_data[31:24] ^ fifo_rd_data[23:16] ^ fifo_rd_data[15:8];
  assign sync_bad  = (fifo_rd_data[31:28] != SYNC_NIBBLE);
  assign csum_bad  = (fifo_rd_data[7:0] != csum_calc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fifo_rd_en  = 1'b0;
    load_out    = 1'b0;
    out_release = 1'b0;
    ok_inc      = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      IDLE: begin
        fifo_rd_en = enable & ~fifo_empty;
        if (fifo_rd_en) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!sync_bad && !csum_bad) begin
          load_out  = 1'b1;
          ok_inc    = 1'b1;
          state_nxt = OUT;
        end else begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_release = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_class <= 2'd0;
    end else begin
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= fifo_rd_data;
        out_class <= fifo_rd_data[27:26];
      end else if (out_release) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear takes priority over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt   <= '0;
      drop_cnt <= '0;
      err_sync <= 1'b0;
      err_csum <= 1'b0;
    end else if (cnt_clr) begin
      ok_cnt   <= '0;
      drop_cnt <= '0;
      err_sync <= 1'b0;
      err_csum <= 1'b0;
    end else begin
      if (ok_inc && (ok_cnt != '1)) begin
        ok_cnt <= ok_cnt + CNT_WIDTH'(1);
      end
      if (drop_inc && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
      err_sync <= err_sync | (drop_inc & sync_bad);
      err_csum <= err_csum | (drop_inc & csum_bad);
    end
  end

endmodule

// File: tb/tb_pkt_fifo_drain_sorter.sv
// Scoreboard bench for pkt_fifo_drain_sorter: FIFO model, reference packet rules, output monitor.
module tb_pkt_fifo_drain_sorter;

  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   fifo_rd_data = 32'd0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          enable;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [1:0]    out_class;
  logic          cnt_clr;
  logic [CW-1:0] ok_cnt;
  logic [CW-1:0] drop_cnt;
  logic          err_sync;
  logic          err_csum;

  always #5 clk = ~clk;

  pkt_fifo_drain_sorter #(.SYNC_NIBBLE(4'hA), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .enable(enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_class(out_class), .cnt_clr(cnt_clr), .ok_cnt(ok_cnt),
    .drop_cnt(drop_cnt), .err_sync(err_sync), .err_csum(err_csum)
  );

  // FIFO model: written by stimulus, popped on the clock; data appears the cycle after a pop.
  logic [31:0] mem [0:1023];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int cyc      = 0;
  int pop_cyc [$];
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[pop_cnt];
      pop_cnt      <= pop_cnt + 1;
      pop_cyc.push_back(cyc);
    end
  end

  // Reference model state
  logic [33:0] exp_q [$];
  int m_ok = 0, m_drop = 0;
  logic m_es = 1'b0, m_ec = 1'b0;
  int checks = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] mk_good(input logic [1:0] c, input logic [17:0] p);
    logic [31:0] w;
    w = {4'hA, c, p, 8'h00};
    w[7:0] = w[31:24] ^ w[23:16] ^ w[15:8];
    return w;
  endfunction

  task automatic send(input logic [31:0] w);
    logic sb, cb;
    mem[push_cnt] = w;
    push_cnt++;
    sb = (w[31:28] != 4'hA);
    cb = (w[7:0] != (w[31:24] ^ w[23:16] ^ w[15:8]));
    if (!sb && !cb) begin
      exp_q.push_back({w[27:26], w});
      if (m_ok < SAT) m_ok++;
    end else begin
      if (m_drop < SAT) m_drop++;
      if (sb) m_es = 1'b1;
      if (cb) m_ec = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_ok = 0; m_drop = 0; m_es = 1'b0; m_ec = 1'b0;
  endtask

  task automatic drain(input string nm);
    int b = 0;
    enable = 1'b1;
    out_ready = 1'b1;
    while ((push_cnt != pop_cnt || exp_q.size() != 0 || out_valid) && b < 2000) begin
      tick();
      b++;
    end
    tick(3);
    checks++;
    if (b >= 2000) begin
      fails++;
      $display("FAIL %s_drain: timed out after %0d cycles, %0d words pending", nm, b, exp_q.size());
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_ok"},   32'(ok_cnt),   32'(m_ok));
    chk({nm, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    chk({nm, "_esync"}, {31'd0, err_sync}, {31'd0, m_es});
    chk({nm, "_ecsum"}, {31'd0, err_csum}, {31'd0, m_ec});
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks hold stability.
  logic        hold = 1'b0;
  logic [31:0] held_d;
  logic [1:0]  held_c;
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n) begin
      checks++;
      if (fifo_rd_en && (fifo_empty || out_valid)) begin
        fails++;
        $display("FAIL rd_en_guard: rd_en=1 empty=%b out_valid=%b", fifo_empty, out_valid);
      end
    end
    if (out_valid) begin
      if (hold) begin
        chk("hold_data", out_data, held_d);
        chk("hold_class", {30'd0, out_class}, {30'd0, held_c});
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out: got %h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[31:0]);
          chk("out_class", {30'd0, out_class}, {30'd0, e[33:32]});
        end
        hold = 1'b0;
      end else begin
        hold   = 1'b1;
        held_d = out_data;
        held_c = out_class;
      end
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    int p0;
    logic [31:0] w;
    rst_n = 1'b1; enable = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_class", {30'd0, out_class}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk_cnt("rst");
    rst_n = 1'b1;
    tick();

    // Single good word: latency and class 0
    enable = 1'b1; out_ready = 1'b1;
    send(32'hA12345C7);
    #1 chk("t1_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    tick();
    chk("t1_valid_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", out_data, 32'hA12345C7);
    chk("t1_class", {30'd0, out_class}, 32'd0);
    chk("t1_ok", 32'(ok_cnt), 32'd1);
    drain("t1");
    chk_cnt("t1");

    // Backpressure: word held, no further pop while held
    out_ready = 1'b0;
    p0 = pop_cnt;
    send(32'hAC12348A);
    send(mk_good(2'd2, 18'h1BEEF));
    tick(7);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_data", out_data, 32'hAC12348A);
    chk("t2_class", {30'd0, out_class}, 32'd3);
    chk("t2_pops", 32'(pop_cnt - p0), 32'd1);
    drain("t2");
    chk_cnt("t2");

    // Drops: checksum error, then sync error
    send(32'hAC12348B);
    drain("t3a");
    chk_cnt("t3a");
    send(32'h5C12347A);
    drain("t3b");
    chk_cnt("t3b");

    // Empty FIFO never popped; back-to-back pops spaced three cycles
    p0 = pop_cnt;
    tick(10);
    chk("t4_idle_pops", 32'(pop_cnt - p0), 32'd0);
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) send(mk_good(2'(i), 18'(i * 777)));
    drain("t4");
    chk("t4_npops", 32'(pop_cyc.size()), 32'd4);
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
      chk("t4_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);
    chk_cnt("t4");

    // enable dropped while a word is held: it completes, nothing new is popped
    out_ready = 1'b0;
    send(mk_good(2'd1, 18'h00123));
    tick(2);
    enable = 1'b0;
    p0 = pop_cnt;
    send(mk_good(2'd3, 18'h3FFFF));
    tick(5);
    out_ready = 1'b1;
    tick(6);
    chk("en_off_pops", 32'(pop_cnt - p0), 32'd0);
    chk("en_off_valid", {31'd0, out_valid}, 32'd0);
    drain("en");
    chk_cnt("en");

    // Randomized traffic with random backpressure and enable
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(2) == 0) begin
        w = mk_good(2'($urandom_range(3)), 18'($urandom));
        case ($urandom_range(3))
          2: w[7:0] = w[7:0] ^ (8'd1 << $urandom_range(7));
          3: w[31:28] = w[31:28] ^ 4'(1 + $urandom_range(14));
          default: ;
        endcase
        send(w);
      end
      out_ready = 1'($urandom_range(1));
      enable = ($urandom_range(3) != 0);
      tick();
    end
    drain("rnd");
    chk_cnt("rnd");

    // Saturation, then clear colliding with an increment
    for (int i = 0; i < SAT + 5; i++) send(mk_good(2'(i), 18'(i)));
    drain("sat");
    chk("sat_ok", 32'(ok_cnt), 32'(SAT));
    chk_cnt("sat");
    send(mk_good(2'd2, 18'h2A2A2));
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    model_clear();
    chk("clr_ok", 32'(ok_cnt), 32'd0);
    drain("clr");
    chk_cnt("clr");

    // Async reset while holding a word in the output register
    out_ready = 1'b0;
    send(32'hA12345C7);
    tick(3);
    chk("t6_valid_pre", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_data", out_data, 32'd0);
    chk("t6_ok", 32'(ok_cnt), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    model_clear();
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    p0 = pop_cnt;
    tick(10);
    chk("t6_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_idle_pops", 32'(pop_cnt - p0), 32'd0);
    chk_cnt("t6");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
